serial_to_parallel_deserializer: RTL

Serial-in, parallel-out receiver that rebuilds WIDTH-bit words from a strobed serial bit stream. It is the receiving end for the team's parallel-load shift registers used as serializers.
- Supports MSB-first and LSB-first framing.
- Completed words go into a one-entry holding register with a valid/ready handshake toward the consumer.
- Sits between a serial link or shifter output and the downstream byte-wide datapath.

---
 rtl/serial_to_parallel_deserializer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_to_parallel_deserializer.sv
// serial_to_parallel_deserializer
// ---------------------------------------------------------------------------
// Rebuilds WIDTH-bit words from a strobed serial bit stream and hands them to
// a consumer through a one-entry holding register.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   : each frame is WIDTH data bits plus a trailing even-parity bit;
//               o_parity_err reports the check for the held word.
//   undefined : frame is WIDTH bits, o_parity_err is tied to 0.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_serial_in    serial data bit
//   i_bit_valid    i_serial_in is sampled on edges where this is 1
//   i_msb_first    1: first bit is bit WIDTH-1, 0: first bit is bit 0
//   i_frame_clear  discards the partially assembled word
//   o_parallel_out holding-register data
//   o_out_valid    holding register contains an unconsumed word
//   i_out_ready    consumer accepts the word when o_out_valid && i_out_ready
//   o_overrun      sticky: a completed word was dropped (cleared by reset)
//   o_busy         a partial word is in progress (bit count != 0)
//   o_parity_err   parity result for the held word
//
// Handshake: a word transfers on every rising edge where o_out_valid and
// i_out_ready are both 1. o_out_valid never drops without a transfer, and
// o_parallel_out is stable while o_out_valid is 1 and no transfer occurs.
// A completing word may refill the register on the same edge it drains.
// ---------------------------------------------------------------------------
module serial_to_parallel_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_serial_in,
    input  logic             i_bit_valid,
    input  logic             i_msb_first,
    input  logic             i_frame_clear,
    output logic [WIDTH-1:0] o_parallel_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_overrun,
    output logic             o_busy,
    output logic             o_parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic             r_dir;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             r_overrun;
    logic             r_perr;
    logic             r_busy;

    logic             w_dir;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;
    logic             w_complete;
    logic             w_accept;
    logic             w_data_bit;
    logic [WIDTH-1:0] w_word;
    logic             w_perr;
    logic [CW-1:0]    w_count_next;

    always_comb begin
        // The first bit of a word uses the live direction input; later bits
        // use the value latched with that first bit.
        w_dir      = (r_count == '0) ? i_msb_first : r_dir;
        w_shifted  = w_dir ? {r_shreg[WIDTH-2:0], i_serial_in}
                           : {i_serial_in, r_shreg[WIDTH-1:1]};
        w_last     = (r_count == CW'(FRAME - 1));
        w_complete = i_bit_valid && !i_frame_clear && w_last;
        // Fill is allowed when empty or when the held word drains this edge.
        w_accept   = w_complete && (!r_valid || i_out_ready);
`ifdef PARITY_CHECK_EN
        // The last bit of the frame is parity: shreg already holds the data.
        w_data_bit = (r_count != CW'(WIDTH));
        w_word     = r_shreg;
        w_perr     = (^r_shreg) ^ i_serial_in;
`else
        w_data_bit = 1'b1;
        w_word     = w_shifted;
        w_perr     = 1'b0;
`endif
        w_count_next = r_count;
        if (i_frame_clear) begin
            w_count_next = '0;
        end else if (i_bit_valid) begin
            w_count_next = w_last ? '0 : r_count + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg   <= '0;
            r_count   <= '0;
            r_dir     <= 1'b0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_perr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_busy  <= (w_count_next != '0);

            if (i_frame_clear) begin
                r_shreg <= '0;
            end else if (i_bit_valid) begin
                if (r_count == '0) begin
                    r_dir <= i_msb_first;
                end
                if (w_data_bit) begin
                    r_shreg <= w_shifted;
                end
            end

            // Holding register is independent of frame_clear.
            if (w_accept) begin
                r_out   <= w_word;
                r_valid <= 1'b1;
                r_perr  <= w_perr;
            end else begin
                if (w_complete) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && i_out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_parallel_out = r_out;
    assign o_out_valid    = r_valid;
    assign o_overrun      = r_overrun;
    assign o_busy         = r_busy;
    assign o_parity_err   = r_perr;

endmodule
